// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Programmable clock divider with glitch-free ratio changes.
//   A new half-period ratio (or a stop request, ratio 0) is accepted over a
//   valid/ready handshake. From STOP the divider starts at once. While running,
//   the request is parked and applied only at the next div_out falling edge,
//   so no high or low phase is ever cut short.
//
// Ports
//   clk_in     in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cfg_div    in   requested half-period in clk_in cycles (0 = stop)
//   cfg_valid  in   cfg_div valid this cycle
//   cfg_ready  out  config can be accepted this cycle (not busy)
//   div_out    out  divided clock, registered
//   tick       out  high for the first clk_in cycle of each div_out high phase
//   active     out  divider running (RUN or SWITCH)
//   busy       out  a config is parked, waiting for the next falling edge
module clk_div_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             div_out,
    output logic             tick,
    output logic             active,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;

    logic             accept;
    logic             wrap;

    assign busy      = (state_q == ST_SWITCH);
    assign active    = (state_q != ST_STOP);
    assign cfg_ready = ~busy;
    assign div_out   = div_q;
    assign tick      = tick_q;

    assign accept = cfg_valid & cfg_ready;
    // cur_div is never 0 outside STOP, so the compare cannot underflow there;
    // cnt stops at cur_div-1, so cnt+1 never overflows even for all-ones ratios.
    assign wrap   = (cnt_q == cur_div_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        div_d      = div_q;
        tick_d     = 1'b0;

        unique case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                div_d = 1'b0;
                if (accept && (cfg_div != '0)) begin
                    cur_div_d = cfg_div;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN, ST_SWITCH: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (wrap) begin
                    div_d  = ~div_q;
                    tick_d = ~div_q;   // rising edge of div_out
                end

                if (state_q == ST_RUN) begin
                    // Toggle due this edge still uses the old ratio.
                    if (accept) begin
                        pend_div_d = cfg_div;
                        state_d    = ST_SWITCH;
                    end
                end else if (wrap && div_q) begin
                    // Falling edge: the only safe point to change ratio.
                    cnt_d     = '0;
                    cur_div_d = pend_div_q;
                    state_d   = (pend_div_q != '0) ? ST_RUN : ST_STOP;
                end
            end

            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
                div_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            cnt_q      <= '0;
            cur_div_q  <= '0;
            pend_div_q <= '0;
            div_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: random config traffic on a default-width instance
// scored against a phase-level model, plus a directed all-ones-ratio run on a
// narrow instance.
module tb_clk_div_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic        cfg_valid;
    logic        cfg_ready, div_out, tick, active, busy;

    logic        s_rst_n;
    logic [3:0]  s_cfg_div;
    logic        s_cfg_valid;
    logic        s_cfg_ready, s_div_out, s_tick, s_active, s_busy;

    int total = 0;
    int bad   = 0;
    bit stim_done  = 1'b0;
    bit small_done = 1'b0;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(.CNT_W(16)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .div_out(div_out), .tick(tick),
        .active(active), .busy(busy)
    );

    clk_div_ctrl #(.CNT_W(4)) dut_small (
        .clk_in(clk_in), .rst_n(s_rst_n), .cfg_div(s_cfg_div), .cfg_valid(s_cfg_valid),
        .cfg_ready(s_cfg_ready), .div_out(s_div_out), .tick(s_tick),
        .active(s_active), .busy(s_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks phases: level, edges left until the next toggle, ratio, parked
    // request. Mode 0 = stopped, 1 = running, 2 = request parked.
    typedef struct packed {
        logic div;
        logic tck;
        logic act;
        logic bsy;
        logic rdy;
    } exp_t;

    exp_t exp_q[$];
    int   m_mode = 0, m_left = 0, m_ratio = 0, m_pend = 0;
    logic m_lvl = 0, m_tick = 0;
    bit   model_on = 1'b0;

    always @(posedge clk_in) begin
        if (model_on) begin
            int  old_mode;
            bit  acc;
            exp_t e;
            if (!rst_n) begin
                m_mode = 0; m_left = 0; m_ratio = 0; m_pend = 0;
                m_lvl = 0; m_tick = 0;
            end else begin
                old_mode = m_mode;
                acc      = cfg_valid && (old_mode != 2);
                m_tick   = 0;
                if (old_mode == 0) begin
                    if (acc && cfg_div != 0) begin
                        m_ratio = cfg_div; m_left = cfg_div; m_lvl = 0; m_mode = 1;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_lvl  = ~m_lvl;
                        m_left = m_ratio;
                        if (m_lvl) m_tick = 1;
                        else if (old_mode == 2) begin
                            m_ratio = m_pend;
                            m_left  = m_pend;
                            m_mode  = (m_pend != 0) ? 1 : 0;
                        end
                    end
                    if (old_mode == 1 && acc) begin
                        m_pend = cfg_div;
                        m_mode = 2;
                    end
                end
            end
            e.div = m_lvl;
            e.tck = m_tick;
            e.act = (m_mode != 0);
            e.bsy = (m_mode == 2);
            e.rdy = (m_mode != 2);
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("div_out",   int'(div_out),   int'(e.div));
            chk("tick",      int'(tick),      int'(e.tck));
            chk("active",    int'(active),    int'(e.act));
            chk("busy",      int'(busy),      int'(e.bsy));
            chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
        end
    end

    // ---------------- random stimulus ----------------
    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_on = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        // Directed start: ratio 3 from STOP, then ratio 1.
        rst_n = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd3;
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
        repeat (12) @(posedge clk_in);
        #1;
        cfg_valid = 1'b1; cfg_div = 16'd1;
        @(posedge clk_in); #1;
        cfg_valid = 1'b0;
        repeat (10) @(posedge clk_in);
        for (int i = 0; i < 6000; i++) begin
            #1;
            rst_n     = ($urandom_range(0, 499) != 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 6) == 0) cfg_div = '0;
            else                           cfg_div = 16'($urandom_range(1, 6));
            @(posedge clk_in);
        end
        #1;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        stim_done = 1'b1;
    end

    // ---------------- all-ones ratio on narrow instance ----------------
    initial begin
        logic prev;
        int   n;
        s_rst_n = 1'b0; s_cfg_valid = 1'b0; s_cfg_div = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("small_reset_div",   int'(s_div_out),   0);
        chk("small_reset_ready", int'(s_cfg_ready), 1);
        chk("small_reset_act",   int'(s_active),    0);
        s_rst_n = 1'b1; s_cfg_valid = 1'b1; s_cfg_div = 4'hF;
        @(posedge clk_in); #1;
        s_cfg_valid = 1'b0;
        chk("small_active", int'(s_active), 1);
        for (int ph = 0; ph < 4; ph++) begin
            prev = s_div_out;
            n = 0;
            do begin
                @(posedge clk_in); #1;
                n++;
            end while (s_div_out == prev && n < 40);
            chk("small_phase_len", n, 15);
            chk("small_tick", int'(s_tick), int'(s_div_out));
        end
        small_done = 1'b1;
    end

    // ---------------- end of run ----------------
    initial begin
        int guard;
        guard = 0;
        while (!(stim_done && small_done) && guard < 20000) begin
            @(posedge clk_in);
            guard++;
        end
        if (!(stim_done && small_done)) begin
            total++; bad++;
            $display("FAIL timeout: stim=%0d small=%0d want 1 1", stim_done, small_done);
        end
        @(negedge clk_in); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the divide-ratio field and internal counter.
REQ-002 Port: clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: cfg_div  input  CNT_W  requested half-period in clk_in cycles; 0 = stop request.
REQ-005 Port: cfg_valid  input  1  cfg_div is valid this cycle.
REQ-006 Port: cfg_ready  output  1  block can accept a config this cycle.
REQ-007 Port: div_out  output  1  divided clock level, registered.
REQ-008 Port: tick  output  1  one-cycle pulse, high during the first clk_in cycle of each div_out high phase.
REQ-009 Port: active  output  1  high when state is RUN or SWITCH.
REQ-010 Port: busy  output  1  high when state is SWITCH (config pending).

Function
REQ-011 The block SHALL implement three states: STOP, RUN, SWITCH.
REQ-012 The block SHALL accept a config only on a cycle where cfg_valid=1 and cfg_ready=1; cfg_valid while cfg_ready=0 SHALL be ignored.
REQ-013 cfg_ready SHALL equal NOT busy (combinational from state).
REQ-014 In STOP, accepting cfg_div!=0 SHALL load cur_div=cfg_div, clear cnt to 0, and enter RUN at that edge; accepting cfg_div=0 SHALL leave state STOP.
REQ-015 In STOP, div_out and tick SHALL be 0 and cnt SHALL hold 0.
REQ-016 In RUN and SWITCH, cnt SHALL increment by 1 each cycle; when cnt==cur_div-1 it SHALL wrap to 0 and div_out SHALL toggle at that edge.
REQ-017 The first div_out rising edge after a STOP->RUN transition at edge E0 SHALL occur at edge E0+cur_div; output period SHALL be exactly 2*cur_div cycles, 50% duty.
REQ-018 cur_div=1 SHALL yield div_out = clk_in/2, toggling every cycle.
REQ-019 tick SHALL be set to 1 at the edge where div_out goes 0->1 and cleared at the next edge.
REQ-020 In RUN, an accepted config SHALL be stored in pend_div and state SHALL enter SWITCH; any div_out toggle due at that same edge SHALL still occur using the old cur_div.
REQ-021 In SWITCH, the block SHALL keep running with the old cur_div until the edge where div_out goes 1->0; at that edge cnt<=0, cur_div<=pend_div, and state<=RUN if pend_div!=0, else STOP.
REQ-022 Ratio changes and stops SHALL therefore occur only at a div_out falling edge; no div_out high or low phase SHALL be shorter than the smaller of old and new cur_div (no runt pulses).
REQ-023 After a SWITCH->RUN transition at edge E1, the new low phase SHALL last new cur_div cycles (next rise at E1+cur_div).
REQ-024 cnt and cur_div SHALL be CNT_W bits unsigned; cfg_div up to 2^CNT_W-1 SHALL be supported without overflow.

Reset
REQ-025 When rst_n=0 at a clk_in rising edge: state=STOP, cnt=0, cur_div=0, pend_div=0, div_out=0, tick=0; hence active=0, busy=0, cfg_ready=1.
REQ-026 Reset SHALL take priority over any simultaneous cfg acceptance or toggle, and SHALL discard any pending config, including mid-phase or in SWITCH.
REQ-027 No output SHALL change asynchronously to clk_in.

Verification
REQ-028 Reset then cfg_div=1 accepted at edge 0 -> div_out rises at edge 1, toggles every edge, tick high every other cycle.
REQ-029 cfg_div=3 from STOP at edge 0 -> div_out rises edge 3, falls edge 6, rises edge 9; tick high only in cycle after edges 3, 9.
REQ-030 Running cfg_div=4, new cfg_div=2 accepted while div_out low -> busy=1, cfg_ready=0, cfg_valid pulses ignored; remaining low+full 4-cycle high phase complete, switch at fall, then 2-cycle phases; busy=0 at switch edge.
REQ-031 Running cfg_div=5, cfg_div=0 accepted mid-high phase -> high phase completes at 5 cycles, div_out falls, state STOP, active=0, div_out stays 0.
REQ-032 Running with config pending in SWITCH, rst_n=0 for one edge -> all outputs at reset values next cycle, pending ratio not applied, cfg_ready=1.
REQ-033 cfg_div=2^CNT_W-1 (65535 at default) -> high and low phases each exactly 65535 cycles; no counter wrap error.
